// File: rtl/sip_tx_bitslice_tri_if.sv
// Byte-controller side bus of the tristate bitslice: tristate word plus
// strobe going in, tap/busy/tristate status coming back.
interface sip_tx_bitslice_tri_if;
  logic [34:0] BIT_CTRL_IN;
  logic [10:0] BIT_CTRL_OUT;

  modport master (output BIT_CTRL_IN, input BIT_CTRL_OUT);
  modport slave  (input BIT_CTRL_IN, output BIT_CTRL_OUT);
endinterface

// File: rtl/sip_tx_bitslice_tri.sv
// Tristate-control slice of a transmit bitslice: serializes the tristate word
// LSB first onto TRI_OUT and keeps a report-only 9-bit output-delay tap.
module sip_tx_bitslice_tri #(
  parameter int    DATA_WIDTH  = 8,
  parameter string DELAY_TYPE  = "FIXED",
  parameter int    DELAY_VALUE = 0,
  parameter logic  INIT        = 1'b1,
  parameter string UPDATE_MODE = "ASYNC"
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RST_DLY,
  sip_tx_bitslice_tri_if.slave    bc,
  input  logic                    CE,
  input  logic                    INC,
  input  logic                    LOAD,
  input  logic [8:0]              CNTVALUEIN,
  input  logic                    EN_VTC,
  output logic                    TRI_OUT,
  output logic [8:0]              CNTVALUEOUT
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [8:0] DV9 = 9'(DELAY_VALUE);
  localparam bit IS_VAR_LOAD = (DELAY_TYPE == "VAR_LOAD");
  localparam bit IS_VAR      = (DELAY_TYPE == "VARIABLE") || IS_VAR_LOAD;
  localparam bit UPD_ASYNC   = (UPDATE_MODE == "ASYNC");
  localparam bit UPD_SYNC    = (UPDATE_MODE == "SYNC");

  if (DATA_WIDTH != 2 && DATA_WIDTH != 4 && DATA_WIDTH != 8) begin : g_bad_width
    $error("sip_tx_bitslice_tri: DATA_WIDTH must be 2, 4 or 8");
  end
  if (DELAY_TYPE != "FIXED" && !IS_VAR) begin : g_bad_type
    $error("sip_tx_bitslice_tri: illegal DELAY_TYPE");
  end
  if (!UPD_ASYNC && !UPD_SYNC && UPDATE_MODE != "MANUAL") begin : g_bad_mode
    $error("sip_tx_bitslice_tri: illegal UPDATE_MODE");
  end
  if (DELAY_VALUE < 0 || DELAY_VALUE > 511) begin : g_bad_value
    $error("sip_tx_bitslice_tri: DELAY_VALUE out of range");
  end

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   sreg_q, sreg_d;
  logic                    tri_q, tri_d;
  logic [8:0]              pend_q, pend_d;
  logic [8:0]              act_q, act_d;

  logic                    strobe;
  logic [DATA_WIDTH-1:0]   word;

  assign strobe = bc.BIT_CTRL_IN[8];
  assign word   = bc.BIT_CTRL_IN[DATA_WIDTH-1:0];

  // Serializer next state: cnt holds the bits still to be emitted after the
  // current one; the extra idle edge with cnt==0 is what drops busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    tri_d   = tri_q;
    if (strobe) begin
      sreg_d  = word >> 1;
      tri_d   = word[0];
      cnt_d   = CNT_W'(DATA_WIDTH - 1);
      state_d = ST_SHIFT;
    end else if (state_q == ST_SHIFT) begin
      if (cnt_q != '0) begin
        tri_d  = sreg_q[0];
        sreg_d = sreg_q >> 1;
        cnt_d  = cnt_q - CNT_W'(1);
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Serializer state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      tri_q   <= INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      tri_q   <= tri_d;
    end
  end

  // Tap command decode; SYNC and MANUAL copy the pre-edge pending value.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    if (RST_DLY) begin
      pend_d = DV9;
      act_d  = DV9;
    end else begin
      if (!EN_VTC && IS_VAR) begin
        if (IS_VAR_LOAD && LOAD && !CE) pend_d = CNTVALUEIN;
        else if (CE && !LOAD)           pend_d = INC ? pend_q + 9'd1 : pend_q - 9'd1;
      end
      if (UPD_ASYNC) begin
        act_d = pend_d;
      end else if (UPD_SYNC) begin
        if (strobe) act_d = pend_q;
      end else if (LOAD && CE && !EN_VTC) begin
        act_d = pend_q;
      end
    end
  end

  // Tap registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend_q <= DV9;
      act_q  <= DV9;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
    end
  end

  assign TRI_OUT         = tri_q;
  assign CNTVALUEOUT     = act_q;
  assign bc.BIT_CTRL_OUT = {tri_q, (state_q == ST_SHIFT), act_q};

endmodule

// File: tb/tb_sip_tx_bitslice_tri.sv
// Scoreboard bench: three differently configured slices share one stimulus
// stream; a reference model predicts every post-edge output.
module tb_sip_tx_bitslice_tri;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, RST_DLY, CE, INC, LOAD, EN_VTC;
  logic [8:0]  CNTVALUEIN;
  logic [34:0] bci;

  sip_tx_bitslice_tri_if if0 ();
  sip_tx_bitslice_tri_if if1 ();
  sip_tx_bitslice_tri_if if2 ();
  assign if0.BIT_CTRL_IN = bci;
  assign if1.BIT_CTRL_IN = bci;
  assign if2.BIT_CTRL_IN = bci;

  logic        tri_o [3];
  logic [8:0]  cvo   [3];
  logic [10:0] bco   [3];
  assign bco[0] = if0.BIT_CTRL_OUT;
  assign bco[1] = if1.BIT_CTRL_OUT;
  assign bco[2] = if2.BIT_CTRL_OUT;

  sip_tx_bitslice_tri #(.DATA_WIDTH(8), .DELAY_TYPE("VARIABLE"), .DELAY_VALUE(511),
                        .INIT(1'b1), .UPDATE_MODE("ASYNC")) u_dut0 (
    .CLK(CLK), .RST(RST), .RST_DLY(RST_DLY), .bc(if0), .CE(CE), .INC(INC), .LOAD(LOAD),
    .CNTVALUEIN(CNTVALUEIN), .EN_VTC(EN_VTC), .TRI_OUT(tri_o[0]), .CNTVALUEOUT(cvo[0]));
  sip_tx_bitslice_tri #(.DATA_WIDTH(4), .DELAY_TYPE("VAR_LOAD"), .DELAY_VALUE(20),
                        .INIT(1'b0), .UPDATE_MODE("SYNC")) u_dut1 (
    .CLK(CLK), .RST(RST), .RST_DLY(RST_DLY), .bc(if1), .CE(CE), .INC(INC), .LOAD(LOAD),
    .CNTVALUEIN(CNTVALUEIN), .EN_VTC(EN_VTC), .TRI_OUT(tri_o[1]), .CNTVALUEOUT(cvo[1]));
  sip_tx_bitslice_tri #(.DATA_WIDTH(2), .DELAY_TYPE("VARIABLE"), .DELAY_VALUE(5),
                        .INIT(1'b1), .UPDATE_MODE("MANUAL")) u_dut2 (
    .CLK(CLK), .RST(RST), .RST_DLY(RST_DLY), .bc(if2), .CE(CE), .INC(INC), .LOAD(LOAD),
    .CNTVALUEIN(CNTVALUEIN), .EN_VTC(EN_VTC), .TRI_OUT(tri_o[2]), .CNTVALUEOUT(cvo[2]));

  // Configuration mirror: delay type 0=VARIABLE 1=VAR_LOAD; mode 0=ASYNC 1=SYNC 2=MANUAL.
  int dw_c [3] = '{8, 4, 2};
  int dv_c [3] = '{511, 20, 5};
  bit init_c [3] = '{1'b1, 1'b0, 1'b1};
  int dt_c [3] = '{0, 1, 0};
  int um_c [3] = '{0, 1, 2};

  // Model state: word being sent and index of its next bit.
  logic [7:0] m_word [3];
  int         m_idx  [3];
  bit         m_tri  [3];
  bit         m_busy [3];
  int         m_pend [3];
  int         m_act  [3];

  typedef struct packed {
    logic [2:0]      t;
    logic [2:0]      b;
    logic [2:0][8:0] tap;
  } exp_t;

  exp_t exp_q [$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int k, input logic [10:0] got, input logic [10:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s dut%0d got %0h want %0h at %0t", name, k, got, want, $time);
    end
  endtask

  // Monitor: every post-edge sample is checked against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
          chk("tri_out", k, {10'd0, tri_o[k]}, {10'd0, e.t[k]});
          chk("cntvalueout", k, {2'd0, cvo[k]}, {2'd0, e.tap[k]});
          chk("bit_ctrl_out", k, bco[k], {e.t[k], e.b[k], e.tap[k]});
        end
      end
    end
  end

  task automatic model_step(input bit rst, input bit stb, input logic [7:0] w, input bit ce,
                            input bit inc, input bit ld, input int cv, input bit env, input bit rd);
    exp_t e;
    int old;
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        m_tri[k] = init_c[k]; m_busy[k] = 1'b0; m_idx[k] = dw_c[k];
        m_pend[k] = dv_c[k]; m_act[k] = dv_c[k];
      end else begin
        if (stb) begin
          m_word[k] = w; m_tri[k] = w[0]; m_idx[k] = 1; m_busy[k] = 1'b1;
        end else if (m_idx[k] < dw_c[k]) begin
          m_tri[k] = m_word[k][m_idx[k]]; m_idx[k]++;
        end else begin
          m_busy[k] = 1'b0;
        end
        old = m_pend[k];
        if (rd) begin
          m_pend[k] = dv_c[k]; m_act[k] = dv_c[k];
        end else begin
          if (!env) begin
            if (dt_c[k] == 1 && ld && !ce) m_pend[k] = cv;
            else if (ce && !ld) m_pend[k] = inc ? (m_pend[k] + 1) % 512 : (m_pend[k] + 511) % 512;
          end
          case (um_c[k])
            0: m_act[k] = m_pend[k];
            1: if (stb) m_act[k] = old;
            default: if (ld && ce && !env) m_act[k] = old;
          endcase
        end
      end
      e.t[k] = m_tri[k];
      e.b[k] = m_busy[k];
      e.tap[k] = 9'(m_act[k]);
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit rst, input bit stb, input logic [7:0] w, input bit ce, input bit inc,
                     input bit ld, input int cv, input bit env, input bit rd);
    logic [31:0] r;
    @(negedge CLK);
    r = $urandom();
    RST = rst; bci = {r[25:0], stb, w}; CE = ce; INC = inc; LOAD = ld;
    CNTVALUEIN = 9'(cv); EN_VTC = env; RST_DLY = rd;
    model_step(rst, stb, w, ce, inc, ld, cv, env, rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    RST = 1'b0; RST_DLY = 1'b0; CE = 1'b0; INC = 1'b0; LOAD = 1'b0; EN_VTC = 1'b0;
    CNTVALUEIN = '0; bci = '0;
    repeat (3) cyc(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Serialize 1011_0010 and let it drain.
    cyc(1, 1, 8'hB2, 0, 0, 0, 0, 0, 0);
    idle(10);
    // Abort: FF then 00 on the third bit.
    cyc(1, 1, 8'hFF, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(1, 1, 8'h00, 0, 0, 0, 0, 0, 0);
    idle(10);
    // Tap wrap both ways, then frozen by EN_VTC.
    cyc(1, 0, 8'h00, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 8'h00, 1, 1, 0, 0, 1, 0);
    idle(1);
    // VAR_LOAD load, seen on SYNC slice only at the next strobe.
    cyc(1, 0, 8'h00, 0, 0, 1, 100, 0, 0);
    idle(2);
    cyc(1, 1, 8'h5A, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(1, 0, 8'h00, 0, 0, 1, 100, 0, 1);
    idle(6);
    // MANUAL: three increments then apply.
    repeat (3) cyc(1, 0, 8'h00, 1, 1, 0, 0, 0, 0);
    idle(1);
    cyc(1, 0, 8'h00, 1, 0, 1, 0, 0, 0);
    idle(2);
    // Reset mid-word.
    cyc(1, 1, 8'h3C, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(199) != 0), ($urandom_range(5) == 0), 8'($urandom()),
          ($urandom_range(2) == 0), 1'($urandom()), ($urandom_range(3) == 0),
          int'($urandom_range(511)), ($urandom_range(4) == 0), ($urandom_range(29) == 0));
    end
    idle(2);
    repeat (3) @(posedge CLK);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
